banked_ram_ctl: RTL and testbench

//  Parametrised banked RAM: BANKS equal banks behind one address/data port, top address bits select bank.

---
 rtl/banked_ram_ctl_pkg.sv | 15 +
 rtl/banked_ram_ctl_if.sv | 27 ++
 rtl/banked_ram_ctl_bank.sv | 34 +++
 rtl/banked_ram_ctl.sv | 118 +++++++++++
 tb/tb_banked_ram_ctl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/banked_ram_ctl_pkg.sv
// Shared types and helpers for the banked RAM controller.
// Holds the FSM state encoding and bank geometry helper.
package xiphos_mem_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    // Bank-local address width for a given total depth and bank count.
    function automatic int bank_aw(input int addr_w, input int banks);
        return addr_w - $clog2(banks);
    endfunction

endpackage

// File: rtl/banked_ram_ctl_if.sv
// Host-side bus of the banked RAM controller.
// Master drives address/data/strobes, slave returns read data and status.
interface banked_ram_ctl_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15
);

    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  in;
    logic              ld;
    logic              rd;
    logic              clr;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              busy;

    modport master (
        output addr, in, ld, rd, clr,
        input  out, out_valid, busy
    );

    modport slave (
        input  addr, in, ld, rd, clr,
        output out, out_valid, busy
    );

endinterface

// File: rtl/banked_ram_ctl_bank.sv
// One RAM bank: single port, synchronous write,
// registered read that returns the word as it was before a same-edge write.
module ram_bank #(
    parameter int WIDTH = 16,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [2**AW];

    // Storage array: written on the edge, never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= d;
        end
    end

    // Read register: samples the pre-write contents and holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (re) begin
            q <= mem[a];
        end
    end

endmodule

// File: rtl/banked_ram_ctl.sv
// Banked RAM controller: BANKS banks behind one port, 1-cycle registered
// read with valid pulse, and a zero-clear sequencer after reset or on request.
module banked_ram_ctl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 15,
    parameter int BANKS  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    banked_ram_ctl_if.slave bus
);

    import xiphos_mem_pkg::*;

    localparam int SEL_W   = $clog2(BANKS);
    localparam int BANK_AW = bank_aw(ADDR_W, BANKS);

    state_t             state;
    state_t             state_nx;
    logic [BANK_AW-1:0] ptr;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_q;
    logic [BANK_AW-1:0] loc;
    logic [BANK_AW-1:0] bank_a;
    logic [WIDTH-1:0]   bank_d;
    logic               clearing;
    logic               rd_ok;
    logic               ld_ok;
    logic               valid_q;
    logic [WIDTH-1:0]   q [BANKS];

    assign sel      = bus.addr[ADDR_W-1 -: SEL_W];
    assign loc      = bus.addr[BANK_AW-1:0];
    assign clearing = (state == CLEAR);

    // While clearing every bank gets a zero at the sweep pointer.
    assign bank_a = clearing ? ptr : loc;
    assign bank_d = clearing ? '0 : bus.in;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and accepted strobes; clr beats rd/ld in RUN.
    always_comb begin
        state_nx = state;
        rd_ok    = 1'b0;
        ld_ok    = 1'b0;
        unique case (state)
            CLEAR: begin
                if (&ptr) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (bus.clr) begin
                    state_nx = CLEAR;
                end else begin
                    rd_ok = bus.rd;
                    ld_ok = bus.ld;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    // Clear sweep pointer; wraps to zero on the last clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clearing) begin
            ptr <= ptr + BANK_AW'(1);
        end else if (bus.clr) begin
            ptr <= '0;
        end
    end

    // Read-valid pulse and the bank select that steers the output mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            valid_q <= rd_ok;
            if (rd_ok) begin
                sel_q <= sel;
            end
        end
    end

    for (genvar i = 0; i < BANKS; i++) begin : g_bank
        logic hit;
        assign hit = (sel == SEL_W'(i));

        ram_bank #(
            .WIDTH (WIDTH),
            .AW    (BANK_AW)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (clearing | (ld_ok & hit)),
            .re    (rd_ok & hit),
            .a     (bank_a),
            .d     (bank_d),
            .q     (q[i])
        );
    end

    assign bus.out       = q[sel_q];
    assign bus.out_valid = valid_q;
    assign bus.busy      = clearing;

endmodule

// File: tb/tb_banked_ram_ctl.sv
// Directed bench for banked_ram_ctl: vector table for RUN-mode traffic
// plus hand sequences for clear, clr collisions and reset during clear.
module tb_banked_ram_ctl;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 6;
    localparam int BANKS  = 4;
    localparam int NVEC   = 19;

    typedef struct {
        logic        rd;
        logic        ld;
        logic [5:0]  addr;
        logic [15:0] din;
        logic        ev;
        logic [15:0] eo;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n;
    bit   saw;
    vec_t tbl [NVEC];

    banked_ram_ctl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    banked_ram_ctl #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .BANKS  (BANKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic c,
                        input logic [5:0] a, input logic [15:0] d);
        bus.rd   = r;
        bus.ld   = l;
        bus.clr  = c;
        bus.addr = a;
        bus.in   = d;
        @(posedge clk);
        #1;
    endtask

    // Drives junk rd/ld while busy; counts edges until busy drops.
    task automatic count_clear(output int cnt, output bit valid_seen);
        cnt = 0;
        valid_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b1, 1'b0, 6'h2A, 16'h1234);
            cnt++;
            if (bus.out_valid) valid_seen = 1'b1;
            if (!bus.busy) break;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 6'h00, 16'h0000, 1'b1, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 6'h11, 16'h0000, 1'b1, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 6'h3F, 16'h0000, 1'b1, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 6'h2A, 16'hBEEF, 1'b0, 16'h0000};
        tbl[5]  = '{1'b1, 1'b0, 6'h2A, 16'h0000, 1'b1, 16'hBEEF};
        tbl[6]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 16'hBEEF};
        tbl[7]  = '{1'b0, 1'b1, 6'h05, 16'h1111, 1'b0, 16'hBEEF};
        tbl[8]  = '{1'b0, 1'b1, 6'h15, 16'h2222, 1'b0, 16'hBEEF};
        tbl[9]  = '{1'b0, 1'b1, 6'h25, 16'h3333, 1'b0, 16'hBEEF};
        tbl[10] = '{1'b0, 1'b1, 6'h35, 16'h4444, 1'b0, 16'hBEEF};
        tbl[11] = '{1'b1, 1'b0, 6'h05, 16'h0000, 1'b1, 16'h1111};
        tbl[12] = '{1'b1, 1'b0, 6'h15, 16'h0000, 1'b1, 16'h2222};
        tbl[13] = '{1'b1, 1'b0, 6'h25, 16'h0000, 1'b1, 16'h3333};
        tbl[14] = '{1'b1, 1'b0, 6'h35, 16'h0000, 1'b1, 16'h4444};
        tbl[15] = '{1'b0, 1'b1, 6'h10, 16'hAAAA, 1'b0, 16'h4444};
        tbl[16] = '{1'b1, 1'b1, 6'h10, 16'h5555, 1'b1, 16'hAAAA};
        tbl[17] = '{1'b1, 1'b0, 6'h10, 16'h0000, 1'b1, 16'h5555};
        tbl[18] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 16'h5555};

        rst_n    = 1'b0;
        bus.rd   = 1'b0;
        bus.ld   = 1'b0;
        bus.clr  = 1'b0;
        bus.addr = '0;
        bus.in   = '0;
        #12;
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h1);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_clear(n, saw);
        check("init_clear_len", 32'(n), 32'd16);
        check("init_clear_valid", 32'(saw), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].rd, tbl[i].ld, 1'b0, tbl[i].addr, tbl[i].din);
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid),
                  32'(tbl[i].ev));
            check($sformatf("vec%0d_out", i), 32'(bus.out), 32'(tbl[i].eo));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'h0);
        end

        step(1'b1, 1'b0, 1'b1, 6'h2A, 16'h0000);
        check("clr_rd_valid", 32'(bus.out_valid), 32'h0);
        check("clr_rd_busy", 32'(bus.busy), 32'h1);
        check("clr_rd_out", 32'(bus.out), 32'h5555);
        count_clear(n, saw);
        check("clr_len", 32'(n), 32'd16);
        check("clr_busy_valid", 32'(saw), 32'h0);
        check("clr_out_hold", 32'(bus.out), 32'h5555);
        step(1'b1, 1'b0, 1'b0, 6'h2A, 16'h0000);
        check("post_clr_valid", 32'(bus.out_valid), 32'h1);
        check("post_clr_2a", 32'(bus.out), 32'h0000);

        step(1'b0, 1'b1, 1'b0, 6'h15, 16'h2222);
        step(1'b1, 1'b0, 1'b0, 6'h15, 16'h0000);
        check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        check("pre_rst_out", 32'(bus.out), 32'h2222);
        rst_n = 1'b0;
        #1;
        check("midrd_valid", 32'(bus.out_valid), 32'h0);
        check("midrd_out", 32'(bus.out), 32'h0);
        check("midrd_busy", 32'(bus.busy), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_clear(n, saw);
        check("midrd_clear_len", 32'(n), 32'd16);

        step(1'b0, 1'b0, 1'b1, 6'h00, 16'h0000);
        saw = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
            if (!bus.busy) saw = 1'b1;
        end
        check("midclr_busy_drop", 32'(saw), 32'h0);
        rst_n = 1'b0;
        #1;
        check("midclr_rst_busy", 32'(bus.busy), 32'h1);
        @(posedge clk);
        #1;
        check("midclr_held_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b1;
        count_clear(n, saw);
        check("midclr_clear_len", 32'(n), 32'd16);
        step(1'b1, 1'b0, 1'b0, 6'h15, 16'h0000);
        check("final_valid", 32'(bus.out_valid), 32'h1);
        check("final_15", 32'(bus.out), 32'h0000);
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        check("final_idle_valid", 32'(bus.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
